// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: filtered PS/2 device-to-host receiver feeding a first-word-fall-through FIFO.
// Optional prefix decoding (E0 -> ext, F0 -> brk) is enabled by defining PS2_RX_PREFIX_DECODE_EN.
module ps2_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_CYC = 200000,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ps2_clk,
   input  logic          ps2_data,
   input  logic          rd_en,
   input  logic          err_clr,
   output logic [7:0]    data,
   output logic          ready,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          parity_err,
   output logic          frame_err
`ifdef PS2_RX_PREFIX_DECODE_EN
   ,
   output logic          ext,
   output logic          brk
`endif
);
`ifdef PS2_RX_PREFIX_DECODE_EN
   localparam int EW = 10;
`else
   localparam int EW = 8;
`endif
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    sync_clk_q, sync_clk_d, sync_dat_q, sync_dat_d;
   logic [FW-1:0] cnt_clk_q, cnt_clk_d, cnt_dat_q, cnt_dat_d;
   logic          filt_clk_q, filt_clk_d, filt_dat_q, filt_dat_d;
   logic          fall_q, fall_d;
   state_t        state_q;
   logic [2:0]    idx_q;
   logic [7:0]    shift_q;
   logic          par_q;
   logic [WW-1:0] wd_q;
   logic          timeout, at_stop, frame_ev, par_ev, valid_ev, is_pfx;
   logic          push_q, push_d, perr_set_q, perr_set_d, ferr_set_q, ferr_set_d;
   logic [EW-1:0] word_q, word_d;
   logic          pend_ext_q, pend_ext_d, pend_brk_q, pend_brk_d;
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;
   logic          do_push, do_pop;
   logic [EW-1:0] head;

   // Synchronise both pins, require FILTER_LEN stable cycles before the filtered level moves.
   always_comb begin
      sync_clk_d = {sync_clk_q[0], ps2_clk};
      sync_dat_d = {sync_dat_q[0], ps2_data};
      cnt_clk_d  = (sync_clk_q[1] == filt_clk_q || cnt_clk_q == FW'(FILTER_LEN - 1)) ? '0 : cnt_clk_q + 1'b1;
      cnt_dat_d  = (sync_dat_q[1] == filt_dat_q || cnt_dat_q == FW'(FILTER_LEN - 1)) ? '0 : cnt_dat_q + 1'b1;
      filt_clk_d = (sync_clk_q[1] != filt_clk_q && cnt_clk_q == FW'(FILTER_LEN - 1)) ? sync_clk_q[1] : filt_clk_q;
      filt_dat_d = (sync_dat_q[1] != filt_dat_q && cnt_dat_q == FW'(FILTER_LEN - 1)) ? sync_dat_q[1] : filt_dat_q;
      fall_d     = filt_clk_q & ~filt_clk_d;
   end

   // Conditioning registers; idle-high lines come out of reset at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_clk_q <= 2'b11;
         sync_dat_q <= 2'b11;
         cnt_clk_q  <= '0;
         cnt_dat_q  <= '0;
         filt_clk_q <= 1'b1;
         filt_dat_q <= 1'b1;
         fall_q     <= 1'b0;
      end else begin
         sync_clk_q <= sync_clk_d;
         sync_dat_q <= sync_dat_d;
         cnt_clk_q  <= cnt_clk_d;
         cnt_dat_q  <= cnt_dat_d;
         filt_clk_q <= filt_clk_d;
         filt_dat_q <= filt_dat_d;
         fall_q     <= fall_d;
      end
   end

   // Frame receiver: start, 8 data bits LSB first, parity, stop; watchdog abandons stalled frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         wd_q <= (state_q == IDLE || fall_q) ? '0 : wd_q + 1'b1;
         if (timeout) begin
            state_q <= IDLE;
         end else if (fall_q) begin
            case (state_q)
               IDLE: begin
                  state_q <= filt_dat_q ? IDLE : DATA;
                  idx_q   <= '0;
               end
               DATA: begin
                  shift_q <= {filt_dat_q, shift_q[7:1]};
                  idx_q   <= idx_q + 1'b1;
                  state_q <= (idx_q == 3'd7) ? PARITY : DATA;
               end
               PARITY: begin
                  par_q   <= filt_dat_q;
                  state_q <= STOP;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Classify the end of each frame into push, parity error or framing error, and track prefixes.
   always_comb begin
      timeout    = state_q != IDLE && !fall_q && wd_q == WW'(TIMEOUT_CYC - 1);
      at_stop    = fall_q && state_q == STOP;
      frame_ev   = timeout || (fall_q && state_q == IDLE && filt_dat_q) || (at_stop && !filt_dat_q);
      par_ev     = at_stop && filt_dat_q && !(^{shift_q, par_q});
      valid_ev   = at_stop && filt_dat_q && (^{shift_q, par_q});
`ifdef PS2_RX_PREFIX_DECODE_EN
      is_pfx     = shift_q == 8'hE0 || shift_q == 8'hF0;
      pend_ext_d = (frame_ev || par_ev) ? 1'b0 : valid_ev ? (shift_q == 8'hE0 ? 1'b1 : shift_q == 8'hF0 ? pend_ext_q : 1'b0) : pend_ext_q;
      pend_brk_d = (frame_ev || par_ev) ? 1'b0 : valid_ev ? (shift_q == 8'hF0 ? 1'b1 : shift_q == 8'hE0 ? pend_brk_q : 1'b0) : pend_brk_q;
      word_d     = {pend_ext_q, pend_brk_q, shift_q};
`else
      is_pfx     = 1'b0;
      pend_ext_d = 1'b0;
      pend_brk_d = 1'b0;
      word_d     = shift_q;
`endif
      push_d     = valid_ev && !is_pfx;
      perr_set_d = par_ev;
      ferr_set_d = frame_ev;
   end

   // Registered receiver outputs; the push lands in the FIFO one cycle after the stop-bit fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         push_q     <= 1'b0;
         word_q     <= '0;
         perr_set_q <= 1'b0;
         ferr_set_q <= 1'b0;
         pend_ext_q <= 1'b0;
         pend_brk_q <= 1'b0;
      end else begin
         push_q     <= push_d;
         word_q     <= word_d;
         perr_set_q <= perr_set_d;
         ferr_set_q <= ferr_set_d;
         pend_ext_q <= pend_ext_d;
         pend_brk_q <= pend_brk_d;
      end
   end

   // FIFO bookkeeping: a full FIFO drops pushes unless a pop frees a slot in the same cycle.
   always_comb begin
      do_pop       = rd_en && count_q != '0;
      do_push      = push_q && (count_q != (AW + 1)'(DEPTH) || do_pop);
      wr_ptr_d     = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d     = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d      = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      overflow_d   = (push_q && !do_push) || (overflow_q && !err_clr);
      parity_err_d = perr_set_q || (parity_err_q && !err_clr);
      frame_err_d  = ferr_set_q || (frame_err_q && !err_clr);
   end

   // FIFO pointers, fill count and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= word_q;
   end

   assign head       = mem_q[rd_ptr_q];
   assign ready      = count_q != '0;
   assign count      = count_q;
   assign data       = ready ? head[7:0] : 8'h00;
   assign overflow   = overflow_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
`ifdef PS2_RX_PREFIX_DECODE_EN
   assign ext        = ready & head[9];
   assign brk        = ready & head[8];
`endif
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed bench for ps2_rx_fifo with a vector table plus hand-written corner sequences.
module tb_ps2_rx_fifo;
   localparam int DP = 8;
   localparam int FL = 8;
   localparam int TO = 400;
   localparam int HP = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] data;
   logic       ready;
   logic [3:0] count;
   logic       overflow, parity_err, frame_err;
`ifdef PS2_RX_PREFIX_DECODE_EN
   logic       ext, brk;
`endif
   int total = 0;
   int bad = 0;

   typedef struct {
      bit         pop;
      bit         clr;
      bit         send;
      logic [7:0] code;
      bit         badpar;
      bit         stopb;
      logic [3:0] e_cnt;
      logic [7:0] e_data;
      bit         e_perr;
      bit         e_ferr;
   } vec_t;
   vec_t tv [11];

   ps2_rx_fifo #(.DEPTH(DP), .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_en(rd_en), .err_clr(err_clr), .data(data), .ready(ready), .count(count),
      .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
`ifdef PS2_RX_PREFIX_DECODE_EN
      , .ext(ext), .brk(brk)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pop();
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
   endtask

   task automatic clr();
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
   endtask

   // Raw stop-bit fall at P0 -> filtered fall at P10 -> push registered P11 -> FIFO updated P12.
   task automatic send_frame(input logic [7:0] code, input bit badpar, input bit stopb, input int nbits,
                             input bit glitch, input bit lat, input bit popc);
      logic [10:0] f;
      f = {stopb, (~^code) ^ badpar, code, 1'b0};
      for (int k = 0; k < nbits; k++) begin
         ps2_data = f[k];
         if (glitch && k == 4) begin
            cyc(5);
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(HP - 8);
         end else cyc(HP);
         ps2_clk = 1'b0;
         for (int i = 1; i <= HP; i++) begin
            cyc(1);
            if (k == 10 && popc) rd_en = (i == 11);
            if (k == 10 && lat && i == 11) chk("lat_before", ready, 0);
            if (k == 10 && lat && i == 12) chk("lat_ready", ready, 1);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      cyc(2 * HP);
   endtask

   task automatic send(input logic [7:0] code);
      send_frame(code, 1'b0, 1'b1, 11, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      tv[0]  = '{0, 0, 1, 8'h1C, 1, 1, 4'd0, 8'h00, 1, 0};
      tv[1]  = '{0, 1, 0, 8'h00, 0, 1, 4'd0, 8'h00, 0, 0};
      tv[2]  = '{0, 0, 1, 8'h5A, 0, 1, 4'd1, 8'h5A, 0, 0};
      tv[3]  = '{0, 0, 1, 8'h3F, 0, 1, 4'd2, 8'h5A, 0, 0};
      tv[4]  = '{1, 0, 0, 8'h00, 0, 1, 4'd1, 8'h3F, 0, 0};
      tv[5]  = '{0, 0, 1, 8'h66, 0, 0, 4'd1, 8'h3F, 0, 1};
      tv[6]  = '{1, 1, 0, 8'h00, 0, 1, 4'd0, 8'h00, 0, 0};
      tv[7]  = '{1, 0, 0, 8'h00, 0, 1, 4'd0, 8'h00, 0, 0};
      tv[8]  = '{0, 0, 1, 8'h80, 0, 1, 4'd1, 8'h80, 0, 0};
      tv[9]  = '{0, 0, 1, 8'h00, 1, 1, 4'd1, 8'h80, 1, 0};
      tv[10] = '{1, 1, 0, 8'h00, 0, 1, 4'd0, 8'h00, 0, 0};

      cyc(3);
      rst = 1'b0;
      cyc(1);
      chk("rst_ready", ready, 0);
      chk("rst_count", count, 0);
      chk("rst_data", data, 8'h00);
      chk("rst_flags", {overflow, parity_err, frame_err}, 0);

      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b1, 1'b0);
      chk("b_data", data, 8'h1C);
      chk("b_count", count, 1);
      pop();
      chk("b_pop_ready", ready, 0);
      chk("b_pop_data", data, 8'h00);

      for (int i = 0; i < 11; i++) begin
         if (tv[i].pop) pop();
         if (tv[i].clr) clr();
         if (tv[i].send) send_frame(tv[i].code, tv[i].badpar, tv[i].stopb, 11, 1'b0, 1'b0, 1'b0);
         chk($sformatf("v%0d_count", i), count, tv[i].e_cnt);
         chk($sformatf("v%0d_ready", i), ready, tv[i].e_cnt != 0);
         chk($sformatf("v%0d_data", i), data, tv[i].e_data);
         chk($sformatf("v%0d_perr", i), parity_err, tv[i].e_perr);
         chk($sformatf("v%0d_ferr", i), frame_err, tv[i].e_ferr);
         chk($sformatf("v%0d_ovf", i), overflow, 0);
      end

      for (int b = 1; b <= 9; b++) send(8'(b));
      chk("full_count", count, 8);
      chk("full_ovf", overflow, 1);
      chk("full_head", data, 8'h01);
      pop();
      chk("pop_keeps_ovf", overflow, 1);
      chk("pop_head", data, 8'h02);
      chk("pop_count", count, 7);
      send(8'h0A);
      chk("refill_count", count, 8);
      clr();
      chk("ovf_clr", overflow, 0);
      send_frame(8'h0B, 1'b0, 1'b1, 11, 1'b1, 1'b0, 1'b1);
      chk("pushpop_count", count, 8);
      chk("pushpop_head", data, 8'h03);
      chk("pushpop_ovf", overflow, 0);
      chk("glitch_ferr", frame_err, 0);
      begin
         logic [7:0] exp_rd [8];
         exp_rd = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B};
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), data, exp_rd[i]);
            pop();
         end
      end
      chk("drain_ready", ready, 0);

      send_frame(8'h00, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
      chk("stall_early", frame_err, 0);
      cyc(TO);
      chk("stall_ferr", frame_err, 1);
      chk("stall_count", count, 0);
      send(8'h29);
      chk("after_to_data", data, 8'h29);
      chk("after_to_count", count, 1);
      clr();
      chk("after_to_clr", frame_err, 0);

      send_frame(8'h55, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("midrst_count", count, 0);
      send(8'h4D);
      chk("midrst_data", data, 8'h4D);
      chk("midrst_ferr", frame_err, 0);
      pop();

`ifdef PS2_RX_PREFIX_DECODE_EN
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      chk("pfx_count", count, 1);
      chk("pfx_data", data, 8'h75);
      chk("pfx_ext", ext, 1);
      chk("pfx_brk", brk, 1);
      pop();
      chk("pfx_empty", {ext, brk}, 0);
      send(8'hF0);
      send_frame(8'h12, 1'b0, 1'b0, 11, 1'b0, 1'b0, 1'b0);
      send(8'h1C);
      chk("pfx2_data", data, 8'h1C);
      chk("pfx2_brk", brk, 0);
      chk("pfx2_ext", ext, 0);
      chk("pfx2_count", count, 1);
      chk("pfx2_ferr", frame_err, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
